// File: rtl/dj_stream_fifo.sv
// dj_stream_fifo
// Multi-channel audio sample buffer. The CPU pushes samples per channel
// through an Avalon-MM slave into per-channel FIFOs. Each sample_tick pops one
// sample from every enabled channel onto a parallel output bus. Each channel
// raises a level interrupt when its fill level falls to a programmable
// threshold, and keeps sticky underrun/overflow flags.
//
// Ports
//   clk_clk        in   system clock
//   reset_reset_n  in   asynchronous active-low reset
//   avs_address    in   {channel, reg[1:0]}
//   avs_write      in   write strobe
//   avs_writedata  in   write data
//   avs_read       in   read strobe
//   avs_readdata   out  read data, registered, latency 1, held until next read
//   sample_tick    in   one-cycle pulse at the sample rate
//   sample_out     out  popped samples, channel c at [c*DATA_W +: DATA_W]
//   sample_valid   out  pulses one cycle after sample_tick
//   irq            out  per-channel interrupt (PEND & IE)
//
// Per-channel registers
//   reg 0  W: push sample           R: fill level
//   reg 1  RW: threshold (reset DEPTH/2)
//   reg 2  bit0 EN, bit1 IE (RW); bit2 PEND, bit3 UNDERRUN, bit4 OVERFLOW (W1C)
//   reg 3  R: current sample_out value of the channel
module dj_stream_fifo #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 64,
    localparam int LVL_W   = $clog2(DEPTH) + 1,
    localparam int AW      = $clog2(CHANNELS) + 2
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset_n,
    input  logic [AW-1:0]              avs_address,
    input  logic                       avs_write,
    input  logic [DATA_W-1:0]          avs_writedata,
    input  logic                       avs_read,
    output logic [DATA_W-1:0]          avs_readdata,
    input  logic                       sample_tick,
    output logic [CHANNELS*DATA_W-1:0] sample_out,
    output logic                       sample_valid,
    output logic [CHANNELS-1:0]        irq
);

    localparam int PW   = $clog2(DEPTH);
    // A single-channel build has no channel field; keep a 1-bit index tied to 0.
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CH_W-1:0]            addr_ch;
    logic [1:0]                 addr_reg;
    logic [CHANNELS*DATA_W-1:0] rd_flat;
    logic [DATA_W-1:0]          rd_mux;

    assign addr_reg = avs_address[1:0];

    if (CHANNELS > 1) begin : g_addr_multi
        assign addr_ch = avs_address[AW-1:2];
    end else begin : g_addr_single
        assign addr_ch = '0;
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PW-1:0]     wr_ptr;
        logic [PW-1:0]     rd_ptr;
        logic [LVL_W-1:0]  level;
        logic [LVL_W-1:0]  level_nx;
        logic [LVL_W-1:0]  thr;
        logic [LVL_W-1:0]  thr_eff;
        logic              en;
        logic              ie;
        logic              pend;
        logic              underrun;
        logic              overflow;
        logic [DATA_W-1:0] samp;
        logic [DATA_W-1:0] rd_word;
        logic              sel;
        logic              wr_data;
        logic              wr_thr;
        logic              wr_ctl;
        logic              empty;
        logic              full;
        logic              pop;
        logic              push_ok;
        logic              pop_ok;
        logic              flush;
        logic              pend_set;

        assign sel     = (addr_ch == CH_W'(c));
        assign wr_data = avs_write && sel && (addr_reg == 2'd0);
        assign wr_thr  = avs_write && sel && (addr_reg == 2'd1);
        assign wr_ctl  = avs_write && sel && (addr_reg == 2'd2);

        assign empty   = (level == '0);
        assign full    = (level == LVL_W'(DEPTH));
        assign pop     = sample_tick && en;
        assign push_ok = wr_data && en && !full;
        // Emptiness is judged before this cycle's push, so a push into an
        // empty FIFO coinciding with a tick underruns and keeps the sample.
        assign pop_ok  = pop && !empty;
        assign flush   = wr_ctl && en && !avs_writedata[0];

        always_comb begin
            level_nx = level;
            if (flush) begin
                level_nx = '0;
            end else if (push_ok && !pop_ok) begin
                level_nx = level + 1'b1;
            end else if (!push_ok && pop_ok) begin
                level_nx = level - 1'b1;
            end
        end

        // A threshold write is compared against in the same cycle it lands,
        // so writing a threshold at or above the current level fires PEND.
        assign thr_eff  = wr_thr ? avs_writedata[LVL_W-1:0] : thr;
        assign pend_set = en && !flush && (level_nx <= thr_eff) &&
                          ((level > thr_eff) || wr_thr);

        always_ff @(posedge clk_clk) begin
            if (push_ok) begin
                mem[wr_ptr] <= avs_writedata;
            end
        end

        always_ff @(posedge clk_clk or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                level    <= '0;
                thr      <= LVL_W'(DEPTH / 2);
                en       <= 1'b0;
                ie       <= 1'b0;
                pend     <= 1'b0;
                underrun <= 1'b0;
                overflow <= 1'b0;
                samp     <= '0;
            end else begin
                level <= level_nx;
                if (flush) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (push_ok) begin
                        wr_ptr <= wr_ptr + 1'b1;
                    end
                    if (pop_ok) begin
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                if (wr_thr) begin
                    thr <= avs_writedata[LVL_W-1:0];
                end
                if (wr_ctl) begin
                    en <= avs_writedata[0];
                    ie <= avs_writedata[1];
                end
                // Sticky flags: a set in the same cycle as a W1C wins.
                pend     <= (pend && !(wr_ctl && avs_writedata[2])) || pend_set;
                underrun <= (underrun && !(wr_ctl && avs_writedata[3])) ||
                            (pop && empty);
                overflow <= (overflow && !(wr_ctl && avs_writedata[4])) ||
                            (wr_data && en && full);
                if (sample_tick) begin
                    samp <= pop_ok ? mem[rd_ptr] : '0;
                end
            end
        end

        always_comb begin
            rd_word = '0;
            case (addr_reg)
                2'd0:    rd_word = DATA_W'(level);
                2'd1:    rd_word = DATA_W'(thr);
                2'd2:    rd_word = DATA_W'({overflow, underrun, pend, ie, en});
                default: rd_word = samp;
            endcase
        end

        assign rd_flat[c*DATA_W +: DATA_W]    = rd_word;
        assign sample_out[c*DATA_W +: DATA_W] = samp;
        assign irq[c]                         = pend && ie;
    end

    // Addresses of channels beyond CHANNELS (non power-of-two counts) read 0.
    always_comb begin
        rd_mux = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (addr_ch == CH_W'(i)) begin
                rd_mux = rd_flat[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            avs_readdata <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= sample_tick;
            if (avs_read) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_dj_stream_fifo.sv
// Self-checking bench for dj_stream_fifo (CHANNELS=2, DATA_W=16, DEPTH=64).
// Stimulus pushes expected read data / sample buses into queues; a monitor
// compares whenever a read completes or sample_valid is high.
module tb_dj_stream_fifo;

    localparam int CH    = 2;
    localparam int DW    = 16;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [2:0]    avs_address;
    logic          avs_write;
    logic [DW-1:0] avs_writedata;
    logic          avs_read;
    logic [DW-1:0] avs_readdata;
    logic          sample_tick;
    logic [CH*DW-1:0] sample_out;
    logic          sample_valid;
    logic [CH-1:0] irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] rq[$];
    logic [31:0] sq[$];

    always #5 clk = ~clk;

    dj_stream_fifo #(
        .CHANNELS(CH),
        .DATA_W(DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk_clk(clk),
        .reset_reset_n(rst_n),
        .avs_address(avs_address),
        .avs_write(avs_write),
        .avs_writedata(avs_writedata),
        .avs_read(avs_read),
        .avs_readdata(avs_readdata),
        .sample_tick(sample_tick),
        .sample_out(sample_out),
        .sample_valid(sample_valid),
        .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: reads complete on the cycle after avs_read; samples when valid.
    initial begin
        logic        rd_was;
        logic [15:0] er;
        logic [31:0] es;
        forever begin
            @(posedge clk);
            rd_was = avs_read;
            @(negedge clk);
            if (rd_was && rst_n) begin
                if (rq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL rd_unexpected: got 0x%04h expected no read", avs_readdata);
                end else begin
                    er = rq.pop_front();
                    chk("readdata", 32'(avs_readdata), 32'(er));
                end
            end
            if (sample_valid) begin
                if (sq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sample_unexpected: got 0x%08h expected no sample", sample_out);
                end else begin
                    es = sq.pop_front();
                    chk("sample_out", sample_out, es);
                end
            end
        end
    end

    // One clock cycle of stimulus, entered and left at posedge+1.
    task automatic do_cycle(input logic w, input logic r, input logic t,
                            input int ch, input int rg, input logic [15:0] d);
        avs_write     = w;
        avs_read      = r;
        sample_tick   = t;
        avs_address   = 3'(ch * 4 + rg);
        avs_writedata = d;
        @(posedge clk);
        #1;
        avs_write   = 1'b0;
        avs_read    = 1'b0;
        sample_tick = 1'b0;
    endtask

    task automatic wr(input int ch, input int rg, input logic [15:0] d);
        do_cycle(1'b1, 1'b0, 1'b0, ch, rg, d);
    endtask

    task automatic rd(input int ch, input int rg, input logic [15:0] exp);
        rq.push_back(exp);
        do_cycle(1'b0, 1'b1, 1'b0, ch, rg, 16'h0);
    endtask

    task automatic tick(input logic [31:0] exp);
        sq.push_back(exp);
        do_cycle(1'b0, 1'b0, 1'b1, 0, 0, 16'h0);
    endtask

    task automatic idle();
        do_cycle(1'b0, 1'b0, 1'b0, 0, 0, 16'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        sample_tick   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_readdata", 32'(avs_readdata), 32'h0);
        chk("rst_sample_out", sample_out, 32'h0);
        chk("rst_sample_valid", 32'(sample_valid), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset register values
        rd(1, 2, 16'h0000);
        rd(1, 1, 16'h0020);
        rd(0, 0, 16'h0000);

        // Basic push / pop ordering on ch0
        wr(0, 2, 16'h0001);
        wr(0, 0, 16'h1111);
        wr(0, 0, 16'h2222);
        wr(0, 0, 16'h3333);
        rd(0, 0, 16'h0003);
        tick(32'h0000_1111);
        tick(32'h0000_2222);
        tick(32'h0000_3333);
        rd(0, 0, 16'h0000);
        rd(0, 3, 16'h3333);
        rd(0, 2, 16'h0001);

        // Threshold interrupt on ch0 (threshold write itself fires PEND: clear it)
        wr(0, 1, 16'h0002);
        wr(0, 2, 16'h0007);
        chk("irq_after_clear0", 32'(irq), 32'h0);
        for (int i = 0; i < 4; i++) wr(0, 0, 16'(16'h0A01 + i));
        tick(32'h0000_0A01);
        chk("irq_before_thr", 32'(irq), 32'h0);
        tick(32'h0000_0A02);
        chk("irq_rise", 32'(irq), 32'h1);
        wr(0, 2, 16'h0007);
        chk("irq_w1c", 32'(irq), 32'h0);
        rd(0, 2, 16'h0003);
        rd(0, 0, 16'h0002);
        tick(32'h0000_0A03);
        tick(32'h0000_0A04);
        wr(0, 2, 16'h0001);

        // ch1 overflow, full drain with pointer wrap, underrun
        wr(1, 2, 16'h0001);
        for (int i = 0; i < 65; i++) wr(1, 0, 16'(16'h5000 + i));
        rd(1, 0, 16'h0040);
        rd(1, 2, 16'h0011);
        for (int i = 0; i < 64; i++) tick({16'(16'h5000 + i), 16'h0000});
        tick(32'h0000_0000);
        rd(1, 2, 16'h001D);
        rd(1, 0, 16'h0000);
        chk("irq_ie_off", 32'(irq), 32'h0);
        wr(0, 2, 16'h0009);
        rd(0, 2, 16'h0001);
        wr(1, 2, 16'h0000);
        rd(1, 2, 16'h001C);

        // Same-cycle push and tick on empty ch0
        sq.push_back(32'h0000_0000);
        do_cycle(1'b1, 1'b0, 1'b1, 0, 0, 16'hABCD);
        rd(0, 2, 16'h0009);
        rd(0, 0, 16'h0001);
        tick(32'h0000_ABCD);
        rd(0, 0, 16'h0000);

        // Flush on EN 1->0 preserves flags
        for (int i = 0; i < 10; i++) wr(0, 0, 16'(16'h0B00 + i));
        rd(0, 0, 16'h000A);
        wr(0, 2, 16'h0000);
        rd(0, 0, 16'h0000);
        rd(0, 2, 16'h0008);
        wr(0, 2, 16'h0003);
        for (int i = 0; i < 4; i++) wr(0, 0, 16'(16'h0C00 + i));
        tick(32'h0000_0C00);
        chk("irq_pre_thrwr", 32'(irq), 32'h0);
        wr(0, 1, 16'h0005);
        chk("irq_thr_written", 32'(irq), 32'h1);
        rd(0, 3, 16'h0C00);
        idle();
        chk("pre_rst_sample", sample_out, 32'h0000_0C00);

        // Asynchronous reset mid-transfer
        avs_write     = 1'b1;
        avs_address   = 3'd0;
        avs_writedata = 16'h0DDD;
        sample_tick   = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_readdata", 32'(avs_readdata), 32'h0);
        chk("mid_rst_sample_out", sample_out, 32'h0);
        chk("mid_rst_sample_valid", 32'(sample_valid), 32'h0);
        chk("mid_rst_irq", 32'(irq), 32'h0);
        avs_write   = 1'b0;
        sample_tick = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rd(0, 0, 16'h0000);
        rd(0, 2, 16'h0000);
        rd(0, 1, 16'h0020);
        tick(32'h0000_0000);
        idle();
        idle();
        chk("rq_drained", 32'(rq.size()), 32'h0);
        chk("sq_drained", 32'(sq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dj_stream_fifo.md
# dj_stream_fifo

Parametrised multi-channel audio sample buffer for the DJ audio path, generalising the fixed left/right stream pair to CHANNELS streams. The CPU pushes samples per channel through an Avalon-MM slave into per-channel FIFOs. A sample-rate tick pops one sample from every enabled channel onto a parallel output bus. Each channel raises its own interrupt when its fill level drops to a programmable threshold, and reports underrun and overflow events.

## Interface
- CHANNELS, 2: number of independent streams; 1..8.
- DATA_W, 16: sample width and Avalon data width.
- DEPTH, 64: FIFO depth per channel; power of two, 4..1024.
- LVL_W, log2(DEPTH)+1: level counter width (localparam).
- AW, log2(CHANNELS)+2: address width (localparam); address = {channel, reg[1:0]}.

- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- avs_address  in  AW  register select.
- avs_write  in  1  write strobe.
- avs_writedata  in  DATA_W  write data.
- avs_read  in  1  read strobe.
- avs_readdata  out  DATA_W  read data, registered.
- sample_tick  in  1  one-cycle pulse at the sample rate.
- sample_out  out  CHANNELS*DATA_W  popped samples; channel c occupies bits [c*DATA_W +: DATA_W].
- sample_valid  out  1  pulses 1 cycle after sample_tick.
- irq  out  CHANNELS  per-channel interrupt, level.

## Operation
- Per-channel registers, selected by reg:
  - reg 0: write pushes a sample; read returns the level, zero-extended.
  - reg 1: threshold, LVL_W bits; reset value DEPTH/2.
  - reg 2: control/status.
    - bit0 EN and bit1 IE are read/write.
    - bit2 PEND, bit3 UNDERRUN and bit4 OVERFLOW are sticky and write-1-to-clear. Writing 0 leaves them unchanged.
  - reg 3: read returns the channel's current sample_out value. Writes are ignored.
- Push:
  - Accepted when EN=1 and level<DEPTH.
  - When level==DEPTH, the push is dropped and OVERFLOW is set.
  - When EN=0, the push is dropped silently.
- Pop, on sample_tick, for each channel with EN=1:
  - level>0: head sample goes to that channel's sample_out; level decrements.
  - level==0: sample_out is set to 0 and UNDERRUN is set.
  - Channels with EN=0 drive 0.
- Simultaneous push and pop on the same channel:
  - Both take effect and the level is unchanged.
  - Emptiness is judged on the level before the push. If the FIFO was empty, underrun is flagged, 0 is output, and the pushed sample is stored.
- PEND:
  - Set in any cycle where EN=1 and the post-update level <= threshold, and the pre-update level > threshold or the threshold was just written.
  - Stays set until cleared by W1C. A W1C in the same cycle as a set condition leaves PEND set.
- irq[c] = PEND & IE for channel c.
- EN write 1->0: flushes the FIFO (pointers and level go to 0). PEND, UNDERRUN and OVERFLOW are preserved.
- Storage: one DEPTH x DATA_W memory per channel, with wrapping read/write pointers of log2(DEPTH) bits. Full and empty are derived from the level counter.
- Reset values: avs_readdata=0, sample_out=0, sample_valid=0, irq=0, all levels 0, all control bits 0, thresholds DEPTH/2.

## Timing
- avs_readdata is valid on the cycle after avs_read, for a fixed read latency of 1. It holds its value until the next read.
- A write takes effect at the clock edge where avs_write is high. The level read back on the following cycle includes it.
- sample_tick at edge N: sample_out and sample_valid update at edge N+1, and the level decrements at edge N+1.
- A tick asserted on consecutive cycles pops on each cycle.
- irq asserts the cycle after the level update that sets PEND. It deasserts the cycle after the W1C write.
- Reset assertion clears all state immediately, mid-transfer included. There are no pending operations after release.
- No back-pressure: every Avalon access completes in one cycle. There is no waitrequest.

## Test plan
- Reset, then read reg 2 and reg 1 of channel 1 -> 0x0000 and 0x0020 (DEPTH=64).
- ch0: EN=1, push 0x1111, 0x2222, 0x3333, then three ticks -> sample_out[15:0] = 0x1111, 0x2222, 0x3333 with sample_valid each time; level reads 0.
- ch0: EN=1, IE=1, threshold=2, push 4 samples, then tick twice -> irq[0] rises 1 cycle after the second pop. Write 0x0007 to reg 2 -> irq[0]=0 on the next cycle.
- ch1: EN=1, push 65 samples -> level=64 and OVERFLOW=1. Tick with ch1 empty -> sample_out[31:16]=0 and UNDERRUN=1.
- ch0 empty, EN=1: push 0xABCD and tick in the same cycle -> output 0, UNDERRUN=1, level=1. The next tick outputs 0xABCD.
- Fill ch0 with 10 samples, write EN=0 -> level=0. Assert reset_reset_n low mid-stream -> all outputs 0 immediately.
